// File: rtl/imem_fetch_pkg.sv
// Shared fetch definitions: FSM state type, default reset PC and PC legality check.
// Reused by the branch and decode logic.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFault
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // A PC is legal when word aligned and inside the 2^addr_w word IMEM.
    function automatic logic pc_legal(input logic [31:0] pc, input int unsigned addr_w);
        return (pc[1:0] == 2'b00) && ((pc >> (addr_w + 32'd2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch-side bus: IMEM address/data plus the valid/ready instruction stream to decode.
interface imem_fetch_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0] imem_pc;
    logic [DATA_W-1:0] imem_instruction;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [31:0]       out_pc;
    logic              out_fault;

    // Fetch unit side.
    modport master (
        output imem_pc,
        input  imem_instruction,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_fault
    );

    // IMEM / decode side.
    modport slave (
        input  imem_pc,
        output imem_instruction,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_fault
    );

endinterface

// File: rtl/imem_fetch.sv
// Instruction fetch unit: owns the PC, drives the IMEM word address, tags returned
// words with their PC and hands them to decode. Handles back-pressure by replaying
// the stalled address, redirects, and illegal-PC faults.
module imem_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DATA_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    imem_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         f2_valid_q, f2_valid_d;
    logic [31:0]  f2_pc_q, f2_pc_d;

    logic         stall;
    logic [31:0]  pc_plus4;

    assign stall    = f2_valid_q & ~bus.out_ready;
    assign pc_plus4 = pc_q + 32'd4;

    // Replaying the F2 address while stalled keeps the registered read data stable.
    assign bus.imem_pc   = stall ? f2_pc_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
    assign bus.out_valid = f2_valid_q & ~redirect & (state_q != StFault);
    assign bus.out_instr = bus.imem_instruction;
    assign bus.out_pc    = f2_pc_q;
    assign bus.out_fault = (state_q == StFault);

    // Next-state: redirect beats stall, stall beats fetch progress.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f2_valid_d = f2_valid_q;
        f2_pc_d    = f2_pc_q;

        if (redirect) begin
            // Illegal targets are still captured in pc_q for debug.
            pc_d       = redirect_pc;
            f2_valid_d = 1'b0;
            if (pc_legal(redirect_pc, ADDR_W)) begin
                state_d = fetch_en ? StRun : StIdle;
            end else begin
                state_d = StFault;
            end
        end else if (stall) begin
            // Hold everything until decode accepts.
        end else begin
            case (state_q)
                StFault: begin
                    f2_valid_d = 1'b0;
                end
                StRun: begin
                    if (!pc_legal(pc_q, ADDR_W)) begin
                        // PC ran off the end of IMEM; the last word has already gone out.
                        state_d    = StFault;
                        f2_valid_d = 1'b0;
                    end else if (fetch_en) begin
                        f2_valid_d = 1'b1;
                        f2_pc_d    = pc_q;
                        pc_d       = pc_plus4;
                    end else begin
                        f2_valid_d = 1'b0;
                        state_d    = StIdle;
                    end
                end
                default: begin
                    f2_valid_d = 1'b0;
                    state_d    = fetch_en ? StRun : StIdle;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            f2_valid_q <= 1'b0;
            f2_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f2_valid_q <= f2_valid_d;
            f2_pc_q    <= f2_pc_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_imem_fetch;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NWORDS = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;

    imem_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_fetch #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0000_0000),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // IMEM: one-cycle registered read, no enable.
    logic [31:0] mem [NWORDS];
    always @(posedge clk) bus.imem_instruction <= mem[bus.imem_pc];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 faulted
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_busy;
    logic [31:0] m_beat_pc;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * NWORDS);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= 0;
            m_pc      <= 32'h0;
            m_busy    <= 1'b0;
            m_beat_pc <= 32'h0;
        end else if (redirect) begin
            m_pc   <= redirect_pc;
            m_busy <= 1'b0;
            m_mode <= legal(redirect_pc) ? (fetch_en ? 1 : 0) : 2;
        end else if (m_busy && !bus.out_ready) begin
            // decode is holding the beat
        end else if (m_mode == 2) begin
            m_busy <= 1'b0;
        end else if (m_mode == 1 && !legal(m_pc)) begin
            m_mode <= 2;
            m_busy <= 1'b0;
        end else if (m_mode == 1 && fetch_en) begin
            m_busy    <= 1'b1;
            m_beat_pc <= m_pc;
            m_pc      <= m_pc + 4;
        end else begin
            m_busy <= 1'b0;
            m_mode <= fetch_en ? 1 : 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit          exp_valid;
        logic [31:0] exp_addr;
        exp_valid = m_busy && !redirect && (m_mode != 2);
        exp_addr  = (m_busy && !bus.out_ready) ? m_beat_pc : m_pc;
        check("model_imem_pc", 32'(bus.imem_pc), (exp_addr / 4) % NWORDS);
        check("model_out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("model_out_fault", 32'(bus.out_fault), 32'(m_mode == 2));
        check("model_out_pc", bus.out_pc, m_beat_pc);
        if (exp_valid) check("model_out_instr", bus.out_instr, mem[(m_beat_pc / 4) % NWORDS]);
    end

    // Accepted beats, for loss/duplication checks in the directed part.
    logic [31:0] beats[$];
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) beats.push_back(bus.out_pc);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_beat(input string name, input logic [31:0] pc, input logic [31:0] ins);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_pc"}, bus.out_pc, pc);
        check({name, "_instr"}, bus.out_instr, ins);
    endtask

    initial begin
        for (int i = 0; i < int'(NWORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        bus.out_ready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        sample();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fault", 32'(bus.out_fault), 32'd0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_imem_pc", 32'(bus.imem_pc), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        sample();

        // Straight-line fetch: first beat two cycles after fetch_en rises.
        next_cycle();
        fetch_en = 1'b1;
        sample();
        check("sl_valid_c0", 32'(bus.out_valid), 32'd0);
        next_cycle();
        sample();
        check("sl_valid_c1", 32'(bus.out_valid), 32'd0);
        next_cycle();
        sample();
        expect_beat("sl_b0", 32'h0, 32'h11);
        next_cycle();
        sample();
        expect_beat("sl_b1", 32'h4, 32'h22);

        // Back-pressure for three cycles on the beat at pc 8.
        next_cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            expect_beat("bp_hold", 32'h8, 32'h33);
            check("bp_imem_pc", 32'(bus.imem_pc), 32'd2);
            if (i < 2) next_cycle();
        end
        next_cycle();
        bus.out_ready = 1'b1;
        sample();
        expect_beat("bp_release", 32'h8, 32'h33);
        next_cycle();
        sample();
        expect_beat("sl_b3", 32'hC, 32'h44);
        next_cycle();
        check("sl_beat_count", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) check("sl_beat_seq", beats[i], 32'(4 * i));

        // Redirect coinciding with an accept drops the F2 beat.
        beats.delete();
        redirect = 1'b1;
        redirect_pc = 32'h0;
        sample();
        check("rd0_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        sample();
        expect_beat("rd0_b0", 32'h0, 32'h11);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        sample();
        check("rd_accept_valid", 32'(bus.out_valid), 32'd0);
        check("rd_accept_pc", bus.out_pc, 32'h4);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("rd_gap_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();
        sample();
        expect_beat("rd_target", 32'h40, mem[16]);
        next_cycle();
        check("rd_beat_count", beats.size(), 2);
        if (beats.size() == 2) check("rd_beat_second", beats[1], 32'h40);

        // Illegal redirect faults; a legal redirect recovers.
        redirect = 1'b1;
        redirect_pc = 32'h42;
        sample();
        check("ill_valid", 32'(bus.out_valid), 32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("ill_fault", 32'(bus.out_fault), 32'd1);
        check("ill_valid_f", 32'(bus.out_valid), 32'd0);
        next_cycle();
        sample();
        check("ill_fault_hold", 32'(bus.out_fault), 32'd1);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h10;
        sample();
        check("rec_fault_pre", 32'(bus.out_fault), 32'd1);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("rec_fault_clr", 32'(bus.out_fault), 32'd0);
        next_cycle();
        sample();
        expect_beat("rec_beat", 32'h10, mem[4]);

        // Last IMEM word is delivered, then fault with no beat at 0x400.
        next_cycle();
        beats.delete();
        redirect = 1'b1;
        redirect_pc = 32'h3FC;
        sample();
        next_cycle();
        redirect = 1'b0;
        sample();
        check("wrap_gap", 32'(bus.out_valid), 32'd0);
        next_cycle();
        sample();
        expect_beat("wrap_last", 32'h3FC, mem[255]);
        check("wrap_nofault", 32'(bus.out_fault), 32'd0);
        next_cycle();
        sample();
        check("wrap_fault", 32'(bus.out_fault), 32'd1);
        check("wrap_novalid", 32'(bus.out_valid), 32'd0);
        next_cycle();
        sample();
        check("wrap_beat_count", beats.size(), 1);
        if (beats.size() == 1) check("wrap_beat_pc", beats[0], 32'h3FC);

        // Asynchronous reset while stalled.
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h20;
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        sample();
        expect_beat("rs_b0", 32'h20, mem[8]);
        next_cycle();
        bus.out_ready = 1'b0;
        sample();
        expect_beat("rs_stall", 32'h24, mem[9]);
        check("rs_stall_addr", 32'(bus.imem_pc), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", 32'(bus.out_valid), 32'd0);
        check("rs_async_fault", 32'(bus.out_fault), 32'd0);
        check("rs_async_pc", bus.out_pc, 32'h0);
        check("rs_async_imem", 32'(bus.imem_pc), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        fetch_en = 1'b1;
        next_cycle();
        next_cycle();
        sample();
        expect_beat("rs_restart", 32'h0, 32'h11);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            fetch_en      = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            redirect      = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'($urandom_range(0, 255)) * 4;
                1: redirect_pc = 32'h3F0 + 32'($urandom_range(0, 3)) * 4;
                2: redirect_pc = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
                default: redirect_pc = 32'h400 + 32'($urandom_range(0, 1000)) * 4;
            endcase
        end
        next_cycle();
        redirect = 1'b0;
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
